elev_display_scan: RTL and testbench

- Multi-digit, time-multiplexed successor to the single-digit elevator status decoder.
- Holds N_DIGITS 4-bit status/floor codes in a shadow register and decodes each to 7-segment plus decimal point.
- Scans the digit anodes with an anti-ghosting gap between digits.
- Sits between the elevator controller FSM and the board's common-segment display bank.

---
 rtl/elev_disp_pkg.sv | 46 ++++
 rtl/elev_seg_decode.sv | 19 +
 rtl/elev_display_scan.sv | 206 ++++++++++++++++++++
 tb/tb_elev_display_scan.sv | 201 ++++++++++++++++++++
 4 files changed

// File: rtl/elev_disp_pkg.sv
// -----------------------------------------------------------------------------
// elev_disp_pkg
// Shared definitions for the multiplexed elevator status display:
//   - status/floor code constants (codes 1..4 are plain digits)
//   - SEG_OFF, the all-dark segment pattern
//   - scan FSM state type
//   - seg_decode(): 4-bit code + dp request -> {dp,a,b,c,d,e,f,g}, active-low
// -----------------------------------------------------------------------------
package elev_disp_pkg;

    localparam logic [3:0] CODE_WAIT   = 4'd0;
    localparam logic [3:0] CODE_UP     = 4'd5;
    localparam logic [3:0] CODE_OPEN   = 4'd6;
    localparam logic [3:0] CODE_CLOSED = 4'd7;
    localparam logic [3:0] CODE_DOWN   = 4'd8;
    localparam logic [3:0] CODE_FLOOR  = 4'd9;

    localparam logic [7:0] SEG_OFF = 8'hFF;

    typedef enum logic {
        SHOW = 1'b0,
        GAP  = 1'b1
    } scan_state_e;

    // Codes 10..15 are invalid; lighting every segment and the dp makes a
    // corrupted code obvious on the panel.
    function automatic logic [7:0] seg_decode(input logic [3:0] code, input logic dp);
        logic [7:0] seg;
        seg = 8'h00;
        case (code)
            CODE_WAIT:   seg = {~dp, 7'b1111110};
            4'd1:        seg = {~dp, 7'b1001111};
            4'd2:        seg = {~dp, 7'b0010010};
            4'd3:        seg = {~dp, 7'b0000110};
            4'd4:        seg = {~dp, 7'b1001100};
            CODE_UP:     seg = {~dp, 7'b0100100};
            CODE_OPEN:   seg = {~dp, 7'b0001000};
            CODE_CLOSED: seg = {~dp, 7'b0110001};
            CODE_DOWN:   seg = {~dp, 7'b0000000};
            CODE_FLOOR:  seg = {~dp, 7'b0011000};
            default:     seg = 8'h00;
        endcase
        return seg;
    endfunction

endpackage

// File: rtl/elev_seg_decode.sv
// -----------------------------------------------------------------------------
// elev_seg_decode
// Combinational segment lookup for one digit.
// Ports:
//   code [3:0] : status/floor code of the digit being driven
//   dp         : decimal point request, 1 = lit
//   seg  [7:0] : {dp,a,b,c,d,e,f,g}, active-low
// -----------------------------------------------------------------------------
module elev_seg_decode
    import elev_disp_pkg::*;
(
    input  logic [3:0] code,
    input  logic       dp,
    output logic [7:0] seg
);

    assign seg = seg_decode(code, dp);

endmodule

// File: rtl/elev_display_scan.sv
// -----------------------------------------------------------------------------
// elev_display_scan
// Time-multiplexed N_DIGITS 7-segment driver for the elevator status panel.
// A shadow register holds all digit codes (loaded atomically), and a two-state
// scan FSM lights one digit at a time with an all-off gap between digits.
//
// Ports:
//   clk         : system clock, rising edge
//   rst         : asynchronous reset, active-low
//   code_in     : digit k code at [4k+3:4k], digit 0 rightmost
//   dp_in       : per-digit decimal point request
//   load        : 1-cycle strobe capturing code_in/dp_in
//   blank       : level, forces the display dark (scan keeps running)
//   blink_mask  : digits to blink (only with DISP_BLINK_EN)
//   seg_out     : {dp,a,b,c,d,e,f,g}, active-low, registered
//   an_out      : digit enables, polarity per AN_ACTIVE_LOW, registered
//   digit_idx   : index of the digit currently driven
//   frame_tick  : 1-cycle pulse when digit_idx becomes 0
//
// Optional feature macro: DISP_BLINK_EN
//   defined   -> blink phase toggles every BLINK_FRAMES frames; masked digits
//                keep their anode off while the phase is 1
//   undefined -> no blink logic; blink_mask is ignored
// -----------------------------------------------------------------------------
module elev_display_scan
    import elev_disp_pkg::*;
#(
    parameter int N_DIGITS      = 4,
    parameter int SCAN_DIV      = 50000,
    parameter int GAP_CYC       = 16,
    parameter int BLINK_FRAMES  = 125,
    parameter bit AN_ACTIVE_LOW = 1'b1,
    localparam int IDX_W        = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [4*N_DIGITS-1:0] code_in,
    input  logic [N_DIGITS-1:0]   dp_in,
    input  logic                  load,
    input  logic                  blank,
    input  logic [N_DIGITS-1:0]   blink_mask,
    output logic [7:0]            seg_out,
    output logic [N_DIGITS-1:0]   an_out,
    output logic [IDX_W-1:0]      digit_idx,
    output logic                  frame_tick
);

    localparam int CNT_MAX = (SCAN_DIV > GAP_CYC) ? SCAN_DIV : GAP_CYC;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);

    localparam logic [CNT_W-1:0]    SHOW_LAST = CNT_W'(SCAN_DIV - 1);
    localparam logic [CNT_W-1:0]    GAP_LAST  = (GAP_CYC > 0) ? CNT_W'(GAP_CYC - 1) : '0;
    localparam logic [IDX_W-1:0]    IDX_LAST  = IDX_W'(N_DIGITS - 1);
    localparam logic [N_DIGITS-1:0] AN_OFF    = {N_DIGITS{AN_ACTIVE_LOW}};

    scan_state_e               state_q, state_d;
    logic [CNT_W-1:0]          cnt_q, cnt_d;
    logic [IDX_W-1:0]          idx_q, idx_d;
    logic                      tick_q, tick_d;
    logic [4*N_DIGITS-1:0]     shadow_code_q, shadow_code_d;
    logic [N_DIGITS-1:0]       shadow_dp_q, shadow_dp_d;
    logic [7:0]                seg_q, seg_d;
    logic [N_DIGITS-1:0]       an_q, an_d;

    logic                      advance;
    logic                      blink_dark;
    logic [4*N_DIGITS-1:0]     code_sh;
    logic [N_DIGITS-1:0]       dp_sh;
    logic [N_DIGITS-1:0]       onehot;
    logic [7:0]                dec_seg;

    // Shadow registers: all digits captured together so a frame never mixes
    // old and new codes.
    always_comb begin
        shadow_code_d = shadow_code_q;
        shadow_dp_d   = shadow_dp_q;
        if (load) begin
            shadow_code_d = code_in;
            shadow_dp_d   = dp_in;
        end
    end

    // Scan FSM: the digit index advances on leaving SHOW, so during a gap
    // digit_idx already names the digit about to be lit.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q + 1'b1;
        idx_d   = idx_q;
        advance = 1'b0;
        case (state_q)
            SHOW: begin
                if (cnt_q == SHOW_LAST) begin
                    cnt_d   = '0;
                    advance = 1'b1;
                    state_d = (GAP_CYC == 0) ? SHOW : GAP;
                end
            end
            GAP: begin
                if (cnt_q == GAP_LAST) begin
                    cnt_d   = '0;
                    state_d = SHOW;
                end
            end
            default: begin
                cnt_d   = '0;
                state_d = SHOW;
            end
        endcase
        if (advance) begin
            idx_d = (idx_q == IDX_LAST) ? '0 : idx_q + 1'b1;
        end
        tick_d = advance && (idx_d == '0);
    end

`ifdef DISP_BLINK_EN
    localparam int BF_W = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

    logic [BF_W-1:0]     blink_cnt_q, blink_cnt_d;
    logic                blink_ph_q, blink_ph_d;
    logic [N_DIGITS-1:0] mask_sh;

    // Phase decision uses the post-edge phase so a digit slot that starts on
    // the toggling frame_tick already sees the new phase.
    always_comb begin
        blink_cnt_d = blink_cnt_q;
        blink_ph_d  = blink_ph_q;
        if (tick_d) begin
            if (blink_cnt_q == BF_W'(BLINK_FRAMES - 1)) begin
                blink_cnt_d = '0;
                blink_ph_d  = ~blink_ph_q;
            end else begin
                blink_cnt_d = blink_cnt_q + 1'b1;
            end
        end
        mask_sh    = blink_mask >> idx_d;
        blink_dark = blink_ph_d & mask_sh[0];
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            blink_cnt_q <= '0;
            blink_ph_q  <= 1'b0;
        end else begin
            blink_cnt_q <= blink_cnt_d;
            blink_ph_q  <= blink_ph_d;
        end
    end
`else
    localparam int unused_blink_frames = BLINK_FRAMES;
    logic unused_blink_mask;

    assign unused_blink_mask = ^blink_mask;
    assign blink_dark        = 1'b0;
`endif

    // Single decoder on the muxed digit; outputs are formed from the next
    // state so seg/an/digit_idx change together on the same edge.
    assign code_sh = shadow_code_q >> {idx_d, 2'b00};
    assign dp_sh   = shadow_dp_q >> idx_d;
    assign onehot  = N_DIGITS'(1) << idx_d;

    elev_seg_decode u_seg_decode (
        .code (code_sh[3:0]),
        .dp   (dp_sh[0]),
        .seg  (dec_seg)
    );

    always_comb begin
        seg_d = SEG_OFF;
        an_d  = AN_OFF;
        if ((state_d == SHOW) && !blank) begin
            seg_d = dec_seg;
            if (!blink_dark) begin
                an_d = AN_ACTIVE_LOW ? ~onehot : onehot;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q       <= SHOW;
            cnt_q         <= '0;
            idx_q         <= '0;
            tick_q        <= 1'b0;
            shadow_code_q <= '0;
            shadow_dp_q   <= '0;
            seg_q         <= SEG_OFF;
            an_q          <= AN_OFF;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            idx_q         <= idx_d;
            tick_q        <= tick_d;
            shadow_code_q <= shadow_code_d;
            shadow_dp_q   <= shadow_dp_d;
            seg_q         <= seg_d;
            an_q          <= an_d;
        end
    end

    assign seg_out    = seg_q;
    assign an_out     = an_q;
    assign digit_idx  = idx_q;
    assign frame_tick = tick_q;

endmodule

// File: tb/tb_elev_display_scan.sv
// -----------------------------------------------------------------------------
// tb_elev_display_scan
// Three scanner configurations driven from one stimulus stream:
//   A: 4 digits, 4-cycle slots, 2-cycle gaps, active-low anodes
//   B: 4 digits, 3-cycle slots, no gap, active-high anodes
//   C: 1 digit, 2-cycle slot, 1-cycle gap
// Expected outputs come from a timeline model: after the k-th edge since
// reset release, the slot position is k mod (SCAN_DIV+GAP_CYC).
// -----------------------------------------------------------------------------
module tb_elev_display_scan;

    localparam int BF = 2;

    logic        clk = 1'b0;
    logic        rst;
    logic        load;
    logic        blank;
    logic [15:0] code_in;
    logic [3:0]  dp_in;
    logic [3:0]  blink_mask;

    logic [7:0]  seg_a, seg_b, seg_c;
    logic [3:0]  an_a, an_b;
    logic [0:0]  an_c;
    logic [1:0]  idx_a, idx_b;
    logic [0:0]  idx_c;
    logic        tick_a, tick_b, tick_c;

    int          n_tests = 0;
    int          n_fail  = 0;
    int          k       = 0;
    int          tcnt [3];
    logic [15:0] m_code;
    logic [3:0]  m_dp;

    logic [6:0]  seg_tbl [10] = '{7'h7E, 7'h4F, 7'h12, 7'h06, 7'h4C,
                                  7'h24, 7'h08, 7'h31, 7'h00, 7'h18};

    always #5 clk = ~clk;

    elev_display_scan #(.N_DIGITS(4), .SCAN_DIV(4), .GAP_CYC(2), .BLINK_FRAMES(BF),
                        .AN_ACTIVE_LOW(1'b1)) dut_a (
        .clk(clk), .rst(rst), .code_in(code_in), .dp_in(dp_in), .load(load),
        .blank(blank), .blink_mask(blink_mask), .seg_out(seg_a), .an_out(an_a),
        .digit_idx(idx_a), .frame_tick(tick_a));

    elev_display_scan #(.N_DIGITS(4), .SCAN_DIV(3), .GAP_CYC(0), .BLINK_FRAMES(BF),
                        .AN_ACTIVE_LOW(1'b0)) dut_b (
        .clk(clk), .rst(rst), .code_in(code_in), .dp_in(dp_in), .load(load),
        .blank(blank), .blink_mask(blink_mask), .seg_out(seg_b), .an_out(an_b),
        .digit_idx(idx_b), .frame_tick(tick_b));

    elev_display_scan #(.N_DIGITS(1), .SCAN_DIV(2), .GAP_CYC(1), .BLINK_FRAMES(BF),
                        .AN_ACTIVE_LOW(1'b1)) dut_c (
        .clk(clk), .rst(rst), .code_in(code_in[3:0]), .dp_in(dp_in[0:0]), .load(load),
        .blank(blank), .blink_mask(blink_mask[0:0]), .seg_out(seg_c), .an_out(an_c),
        .digit_idx(idx_c), .frame_tick(tick_c));

    function automatic logic [7:0] ref_seg(input logic [3:0] c, input logic dp);
        if (c > 4'd9) return 8'h00;
        return {~dp, seg_tbl[c]};
    endfunction

    task automatic expect_eq(input string tag, input logic [7:0] got, input logic [7:0] exp);
        n_tests++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic check_dut(input string tag, input int d, input int n, input int s,
                             input int g, input bit al, input logic [7:0] seg_o,
                             input logic [3:0] an_o, input logic [1:0] idx_o,
                             input logic tick_o);
        int         p, slot, w, dig;
        bit         lit, adv, tk, dark;
        logic [7:0] e_seg;
        logic [3:0] oh, nmask, e_an;
        p    = s + g;
        slot = k / p;
        w    = k % p;
        lit  = (w < s);
        dig  = lit ? (slot % n) : ((slot + 1) % n);
        adv  = (g > 0) ? (w == s) : (w == 0 && k > 0);
        tk   = adv && (dig == 0);
        if (tk) tcnt[d]++;
        dark = 1'b0;
`ifdef DISP_BLINK_EN
        dark = (((tcnt[d] / BF) % 2) == 1) && blink_mask[dig];
`endif
        e_seg = (lit && !blank) ? ref_seg(m_code[4*dig +: 4], m_dp[dig]) : 8'hFF;
        oh    = (lit && !blank && !dark) ? 4'(1 << dig) : 4'b0000;
        nmask = 4'((1 << n) - 1);
        e_an  = al ? (~oh & nmask) : oh;
        expect_eq({tag, ".seg"},  seg_o, e_seg);
        expect_eq({tag, ".an"},   {4'b0, an_o}, {4'b0, e_an});
        expect_eq({tag, ".idx"},  {6'b0, idx_o}, 8'(dig));
        expect_eq({tag, ".tick"}, {7'b0, tick_o}, {7'b0, tk});
    endtask

    task automatic step();
        @(posedge clk);
        k++;
        #1;
        check_dut("A", 0, 4, 4, 2, 1'b1, seg_a, an_a, idx_a, tick_a);
        check_dut("B", 1, 4, 3, 0, 1'b0, seg_b, an_b, idx_b, tick_b);
        check_dut("C", 2, 1, 2, 1, 1'b1, seg_c, {3'b0, an_c}, {1'b0, idx_c}, tick_c);
        if (load) begin
            m_code = code_in;
            m_dp   = dp_in;
        end
    endtask

    task automatic run(input int n);
        repeat (n) step();
    endtask

    task automatic reset_check(input string tag);
        expect_eq({tag, ".A.seg"},  seg_a, 8'hFF);
        expect_eq({tag, ".A.an"},   {4'b0, an_a}, 8'h0F);
        expect_eq({tag, ".A.idx"},  {6'b0, idx_a}, 8'h00);
        expect_eq({tag, ".A.tick"}, {7'b0, tick_a}, 8'h00);
        expect_eq({tag, ".B.seg"},  seg_b, 8'hFF);
        expect_eq({tag, ".B.an"},   {4'b0, an_b}, 8'h00);
        expect_eq({tag, ".C.seg"},  seg_c, 8'hFF);
        expect_eq({tag, ".C.an"},   {7'b0, an_c}, 8'h01);
    endtask

    task automatic release_reset();
        @(negedge clk);
        rst    = 1'b1;
        k      = 0;
        m_code = '0;
        m_dp   = '0;
        for (int i = 0; i < 3; i++) tcnt[i] = 0;
    endtask

    initial begin
        rst        = 1'b0;
        load       = 1'b0;
        blank      = 1'b0;
        code_in    = '0;
        dp_in      = '0;
        blink_mask = '0;
        m_code     = '0;
        m_dp       = '0;
        repeat (2) @(posedge clk);
        #1;
        reset_check("rst_init");
        release_reset();

        // Idle after reset: dashes on every digit.
        run(30);

        // Digits 4,3,2,1 from right to left.
        code_in = 16'h1234; dp_in = 4'b0000; load = 1'b1; run(1);
        load = 1'b0; run(50);

        // Fault code with dp on digit 2, OPEN with dp on digit 1.
        code_in = 16'h2B63; dp_in = 4'b0110; load = 1'b1; run(1);
        load = 1'b0; run(30);

        // Blank mid-frame with a load accepted while dark.
        blank = 1'b1; run(10);
        code_in = 16'h9875; dp_in = 4'b1001; load = 1'b1; run(1);
        load = 1'b0; run(10);
        blank = 1'b0; run(30);

        // Randomized loads, blanking and masks.
        for (int i = 0; i < 400; i++) begin
            load       = ($urandom_range(0, 7) == 0);
            code_in    = 16'($urandom);
            dp_in      = 4'($urandom);
            blink_mask = 4'($urandom);
            if ($urandom_range(0, 15) == 0) blank = ~blank;
            run(1);
        end
        load  = 1'b0;
        blank = 1'b0;
        run(3);

        // Asynchronous reset between clock edges.
        #2 rst = 1'b0;
        #1;
        reset_check("rst_mid");
        @(posedge clk);
        #1;
        reset_check("rst_hold");
        release_reset();
        run(40);

        // Digit 0 in the blink mask over several frames.
        code_in = 16'h1234; dp_in = 4'b0000; load = 1'b1; run(1);
        load = 1'b0; blink_mask = 4'b0001; run(240);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
